// File: rtl/hex_debug_rx.sv
// rtl/hex_debug_rx.sv - debug UART receiver: 8N1 deserialiser plus ASCII hex pair decoder
// Build option: define HEX_DEBUG_RX_PARITY_EN for 8E1 frames with even-parity checking.
module hex_debug_rx #(
  parameter int CLK_DIV  = 163,
  parameter int SB_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       hex_err
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [3:0] SB_LAST = 4'(SB_TICKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;

  rx_state_t   state, state_nx;
  logic        rx_meta, rxs;
  logic [CW-1:0] cnt;
  logic        tick;
  logic [3:0]  s;
  logic [2:0]  nbit;
  logic [7:0]  shreg;
  logic        par_bad;
  logic        stop_sample, char_done_d, frame_err_d, char_done_q;
  logic        nib_lo;
  logic [3:0]  hi_nib;
  logic        dec_hex, dec_sep;
  logic [3:0]  dec_nib;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      cnt     <= '0;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
      cnt     <= tick ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!rxs) state_nx = S_START;
      S_START:  if (tick && s == 4'd7) state_nx = rxs ? S_IDLE : S_DATA;
`ifdef HEX_DEBUG_RX_PARITY_EN
      S_DATA:   if (tick && s == 4'd15 && nbit == 3'd7) state_nx = S_PARITY;
      S_PARITY: if (tick && s == 4'd15) state_nx = S_STOP;
`else
      S_DATA:   if (tick && s == 4'd15 && nbit == 3'd7) state_nx = S_STOP;
`endif
      S_STOP:   if (tick && s == SB_LAST) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    stop_sample = (state == S_STOP) && tick && (s == SB_LAST);
    char_done_d = stop_sample && rxs && !par_bad;
    frame_err_d = stop_sample && (!rxs || par_bad);
  end

  // Sample counter s restarts at each sample point so every bit is taken mid-cell.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s     <= '0;
      nbit  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          s    <= '0;
          nbit <= '0;
        end
        S_START: if (tick) s <= (s == 4'd7) ? 4'd0 : s + 4'd1;
        S_DATA: if (tick) begin
          if (s == 4'd15) begin
            shreg <= {rxs, shreg[7:1]};
            s     <= '0;
            nbit  <= nbit + 3'd1;
          end else begin
            s <= s + 4'd1;
          end
        end
        default: if (tick) s <= (s == 4'd15) ? 4'd0 : s + 4'd1;
      endcase
    end
  end

`ifdef HEX_DEBUG_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          par_bad <= 1'b0;
    else if (state == S_IDLE)                            par_bad <= 1'b0;
    else if (state == S_PARITY && tick && s == 4'd15)    par_bad <= ^{shreg, rxs};
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_done_q <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      char_done_q <= char_done_d;
      frame_err   <= frame_err_d;
    end
  end

  always_comb begin
    dec_hex = 1'b0;
    dec_sep = 1'b0;
    dec_nib = 4'd0;
    if (shreg >= 8'h30 && shreg <= 8'h39) begin
      dec_hex = 1'b1;
      dec_nib = shreg[3:0];
    end else if ((shreg >= 8'h41 && shreg <= 8'h46) || (shreg >= 8'h61 && shreg <= 8'h66)) begin
      dec_hex = 1'b1;
      dec_nib = shreg[3:0] + 4'd9;
    end else if (shreg == 8'h0D || shreg == 8'h0A || shreg == 8'h20) begin
      dec_sep = 1'b1;
    end
  end

  // Nibble pairing: separators and errors drop any pending high nibble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nib_lo     <= 1'b0;
      hi_nib     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      hex_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      hex_err    <= 1'b0;
      if (char_done_q) begin
        if (dec_hex) begin
          if (!nib_lo) begin
            hi_nib <= dec_nib;
            nib_lo <= 1'b1;
          end else begin
            data       <= {hi_nib, dec_nib};
            data_valid <= 1'b1;
            nib_lo     <= 1'b0;
          end
        end else begin
          hex_err <= !dec_sep;
          nib_lo  <= 1'b0;
        end
      end else if (frame_err) begin
        nib_lo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hex_debug_rx.sv
// tb/tb_hex_debug_rx.sv - directed table-driven bench for hex_debug_rx
module tb_hex_debug_rx;

  localparam int CLK_DIV  = 2;
  localparam int BIT_CLKS = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] data;
  logic       data_valid, frame_err, hex_err;

  hex_debug_rx #(.CLK_DIV(CLK_DIV), .SB_TICKS(16)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx),
    .data(data), .data_valid(data_valid), .frame_err(frame_err), .hex_err(hex_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    bit         bad_stop;
    bit         bad_par;
    int         dv;
    int         fe;
    int         he;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0, n_err = 0;
  int dv_cnt = 0, fe_cnt = 0, he_cnt = 0, wide_cnt = 0;
  logic dv_p = 1'b0, fe_p = 1'b0, he_p = 1'b0;

  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (frame_err)  fe_cnt++;
    if (hex_err)    he_cnt++;
    if ((data_valid && dv_p) || (frame_err && fe_p) || (hex_err && he_p)) wide_cnt++;
    if (int'(data_valid) + int'(frame_err) + int'(hex_err) > 1) wide_cnt++;
    dv_p = data_valid;
    fe_p = frame_err;
    he_p = hex_err;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] c, input bit bad_stop, input bit bad_par);
    uart_rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = c[i];
      wait_clks(BIT_CLKS);
    end
`ifdef HEX_DEBUG_RX_PARITY_EN
    uart_rx = (^c) ^ bad_par;
    wait_clks(BIT_CLKS);
`endif
    if (bad_stop) begin
      uart_rx = 1'b0;
      wait_clks(BIT_CLKS / 2 + 8);
      uart_rx = 1'b1;
      wait_clks(BIT_CLKS / 2 - 8);
    end else begin
      uart_rx = 1'b1;
      wait_clks(BIT_CLKS);
    end
    uart_rx = 1'b1;
    wait_clks(BIT_CLKS);
  endtask

  function automatic void add(input logic [7:0] ch, input bit bs, input bit bp,
                              input int dv, input int fe, input int he, input logic [7:0] d);
    vq.push_back('{ch, bs, bp, dv, fe, he, d});
  endfunction

  initial begin
    int dv0, fe0, he0;

    add("3", 0, 0, 0, 0, 0, 8'h00);
    add("c", 0, 0, 1, 0, 0, 8'h3C);
    add("F", 0, 0, 0, 0, 0, 8'h3C);
    add("0", 0, 0, 1, 0, 0, 8'hF0);
    add("A", 0, 0, 0, 0, 0, 8'hF0);
    add(8'h0D, 0, 0, 0, 0, 0, 8'hF0);
    add("5", 0, 0, 0, 0, 0, 8'hF0);
    add("5", 0, 0, 1, 0, 0, 8'h55);
    add("G", 0, 0, 0, 0, 1, 8'h55);
    add("1", 1, 0, 0, 1, 0, 8'h55);
    add("2", 0, 0, 0, 0, 0, 8'h55);
    add("3", 0, 0, 1, 0, 0, 8'h23);
`ifdef HEX_DEBUG_RX_PARITY_EN
    add("A", 0, 1, 0, 1, 0, 8'h23);
`endif
    add("7", 0, 0, 0, 0, 0, 8'h23);
    add("7", 0, 0, 1, 0, 0, 8'h77);
    add("a", 0, 0, 0, 0, 0, 8'h77);
    add(" ", 0, 0, 0, 0, 0, 8'h77);
    add("e", 0, 0, 0, 0, 0, 8'h77);
    add("9", 0, 0, 1, 0, 0, 8'hE9);

    // Reset held with a toggling line
    for (int i = 0; i < 20; i++) begin
      uart_rx = ~uart_rx;
      wait_clks(7);
    end
    check("reset_data", int'(data), 8'h00);
    check("reset_dv", dv_cnt + fe_cnt + he_cnt, 0);
    uart_rx = 1'b1;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(200);
    check("post_reset_quiet", dv_cnt + fe_cnt + he_cnt, 0);

    foreach (vq[k]) begin
      dv0 = dv_cnt; fe0 = fe_cnt; he0 = he_cnt;
      send_char(vq[k].ch, vq[k].bad_stop, vq[k].bad_par);
      wait_clks(8);
      check($sformatf("v%0d_dv", k), dv_cnt - dv0, vq[k].dv);
      check($sformatf("v%0d_fe", k), fe_cnt - fe0, vq[k].fe);
      check($sformatf("v%0d_he", k), he_cnt - he0, vq[k].he);
      check($sformatf("v%0d_data", k), int'(data), int'(vq[k].exp_data));
    end

    // Glitch: 4 ticks low on an idle line
    dv0 = dv_cnt; fe0 = fe_cnt; he0 = he_cnt;
    uart_rx = 1'b0;
    wait_clks(4 * CLK_DIV);
    uart_rx = 1'b1;
    wait_clks(400);
    check("glitch_quiet", (dv_cnt - dv0) + (fe_cnt - fe0) + (he_cnt - he0), 0);
    check("glitch_data", int'(data), 8'hE9);

    // Reset during bit 4 of 'B', then a clean 'B','E'
    uart_rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      uart_rx = (8'h42 >> i) & 1'b1;
      wait_clks(BIT_CLKS);
    end
    uart_rx = 1'b0;
    wait_clks(BIT_CLKS / 2);
    reset = 1'b0;
    wait_clks(5);
    uart_rx = 1'b1;
    wait_clks(3);
    check("midreset_data", int'(data), 8'h00);
    reset = 1'b1;
    wait_clks(100);
    dv0 = dv_cnt; fe0 = fe_cnt; he0 = he_cnt;
    send_char("B", 0, 0);
    send_char("E", 0, 0);
    wait_clks(8);
    check("midreset_dv", dv_cnt - dv0, 1);
    check("midreset_err", (fe_cnt - fe0) + (he_cnt - he0), 0);
    check("midreset_result", int'(data), 8'hBE);

    check("pulse_width", wide_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
